rc4_stream_cipher: RTL and testbench

//  Byte-stream RC4 cipher between UART RX byte output and UART TX byte input.
//  - Latches an 80-bit key and runs the RC4 key schedule (KSA).
//  - XORs each received byte with the next PRGA keystream byte.
//  - Hands the result to the transmitter over a valid/ready handshake.

---
 rtl/rc4_stream_cipher.sv | 224 ++++++++++++++++++++++
 tb/tb_rc4_stream_cipher.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_stream_cipher.sv
// rtl/rc4_stream_cipher.sv - RC4 byte-stream cipher between UART RX and UART TX
//
// Purpose:
//   Latches a KEY_BYTES-byte key, runs the RC4 key schedule over a 256-entry
//   register S-box, then XORs every accepted byte with the next keystream byte
//   and offers the result on a valid/ready output. Encrypt and decrypt are the
//   same operation with the same key.
//
// Optional feature macro: RC4_DROP_EN
//   Defined   : after the key schedule, DROP_N keystream bytes are generated and
//               discarded (two cycles each) before the block becomes ready.
//   Undefined : the key schedule goes straight to ready; DROP_N is ignored.
//
// Ports:
//   clk        in   1            system clock
//   rst_n      in   1            asynchronous active-low reset
//   key_in     in   8*KEY_BYTES  key, byte k = key_in[8k+7:8k], byte 0 used first
//   key_load   in   1            pulse: latch key_in and (re)start the key schedule
//   key_ready  out  1            key schedule finished, cipher usable
//   in_valid   in   1            in_data valid
//   in_data    in   8            plaintext / ciphertext byte
//   in_ready   out  1            byte is accepted this cycle when in_valid is high
//   out_valid  out  1            out_data valid
//   out_data   out  8            in_data XOR keystream byte
//   out_ready  in   1            consumer takes out_data this cycle

module rc4_stream_cipher #(
   parameter int KEY_BYTES = 10,
   parameter int DROP_N    = 256
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [8*KEY_BYTES-1:0] key_in,
   input  logic                   key_load,
   output logic                   key_ready,
   input  logic                   in_valid,
   input  logic [7:0]             in_data,
   output logic                   in_ready,
   output logic                   out_valid,
   output logic [7:0]             out_data,
   input  logic                   out_ready
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_INIT  = 3'd1;
   localparam logic [2:0] ST_KSA   = 3'd2;
   localparam logic [2:0] ST_READY = 3'd3;
   localparam logic [2:0] ST_SWAP  = 3'd4;
   localparam logic [2:0] ST_KEYX  = 3'd5;
   localparam logic [2:0] ST_OUT   = 3'd6;
`ifdef RC4_DROP_EN
   localparam logic [2:0] ST_DROP  = 3'd7;
`endif

   logic [2:0]             state_q, state_d;
   logic [7:0]             i_q, i_d;
   logic [7:0]             j_q, j_d;
   logic [7:0]             key_idx_q, key_idx_d;
   logic [7:0]             byte_q, byte_d;
   logic [7:0]             out_data_q, out_data_d;
   logic [8*KEY_BYTES-1:0] key_q, key_d;
`ifdef RC4_DROP_EN
   logic                   drop_ph_q, drop_ph_d;
   logic [15:0]            drop_cnt_q, drop_cnt_d;
`endif

   // S-box: plain registers, no reset; every key_load reinitialises it in INIT.
   logic [7:0] sbox_q [256];

   logic [7:0] key_byte;
   logic [7:0] swap_a;
   logic [7:0] j_new;
   logic [7:0] t_idx;
   logic       s_init;
   logic       s_swap;

   // Current key byte selected by key_idx (wraps at KEY_BYTES-1 in the KSA).
   always_comb begin
      key_byte = '0;
      for (int k = 0; k < KEY_BYTES; k++) begin
         if (key_idx_q == 8'(k)) key_byte = key_q[8*k +: 8];
      end
   end

   // One swap datapath serves both phases: in the KSA the first index is the
   // counter (held in i) and the key byte is mixed into j; in SWAP/DROP the
   // first index is i+1 and no key byte is added.
   always_comb begin
      swap_a = (state_q == ST_KSA) ? i_q : i_q + 8'd1;
      j_new  = j_q + sbox_q[swap_a] + ((state_q == ST_KSA) ? key_byte : 8'd0);
      t_idx  = sbox_q[i_q] + sbox_q[j_q];
   end

   always_comb begin
      state_d    = state_q;
      i_d        = i_q;
      j_d        = j_q;
      key_idx_d  = key_idx_q;
      byte_d     = byte_q;
      out_data_d = out_data_q;
      key_d      = key_q;
      s_init     = 1'b0;
      s_swap     = 1'b0;
`ifdef RC4_DROP_EN
      drop_ph_d  = drop_ph_q;
      drop_cnt_d = drop_cnt_q;
`endif
      // key_load overrides every handshake and aborts any byte in flight.
      if (key_load) begin
         key_d   = key_in;
         state_d = ST_INIT;
      end else begin
         case (state_q)
            ST_IDLE: ;
            ST_INIT: begin
               s_init    = 1'b1;
               i_d       = 8'd0;
               j_d       = 8'd0;
               key_idx_d = 8'd0;
`ifdef RC4_DROP_EN
               drop_ph_d  = 1'b0;
               drop_cnt_d = 16'd0;
`endif
               state_d   = ST_KSA;
            end
            ST_KSA: begin
               s_swap    = 1'b1;
               j_d       = j_new;
               i_d       = i_q + 8'd1;
               key_idx_d = (key_idx_q == 8'(KEY_BYTES - 1)) ? 8'd0 : key_idx_q + 8'd1;
               if (i_q == 8'd255) begin
                  i_d = 8'd0;
                  j_d = 8'd0;
`ifdef RC4_DROP_EN
                  state_d = (DROP_N > 0) ? ST_DROP : ST_READY;
`else
                  state_d = ST_READY;
`endif
               end
            end
            ST_READY: begin
               if (in_valid) begin
                  byte_d  = in_data;
                  state_d = ST_SWAP;
               end
            end
            ST_SWAP: begin
               s_swap  = 1'b1;
               i_d     = swap_a;
               j_d     = j_new;
               state_d = ST_KEYX;
            end
            ST_KEYX: begin
               out_data_d = byte_q ^ sbox_q[t_idx];
               state_d    = ST_OUT;
            end
            ST_OUT: begin
               if (out_ready) state_d = ST_READY;
            end
`ifdef RC4_DROP_EN
            ST_DROP: begin
               if (!drop_ph_q) begin
                  s_swap    = 1'b1;
                  i_d       = swap_a;
                  j_d       = j_new;
                  drop_ph_d = 1'b1;
               end else begin
                  // Second cycle of a dropped byte: its keystream value is discarded.
                  drop_ph_d  = 1'b0;
                  drop_cnt_d = drop_cnt_q + 16'd1;
                  if (drop_cnt_q == 16'(DROP_N - 1)) state_d = ST_READY;
               end
            end
`endif
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         i_q        <= 8'd0;
         j_q        <= 8'd0;
         key_idx_q  <= 8'd0;
         byte_q     <= 8'd0;
         out_data_q <= 8'd0;
         key_q      <= '0;
`ifdef RC4_DROP_EN
         drop_ph_q  <= 1'b0;
         drop_cnt_q <= 16'd0;
`endif
      end else begin
         state_q    <= state_d;
         i_q        <= i_d;
         j_q        <= j_d;
         key_idx_q  <= key_idx_d;
         byte_q     <= byte_d;
         out_data_q <= out_data_d;
         key_q      <= key_d;
`ifdef RC4_DROP_EN
         drop_ph_q  <= drop_ph_d;
         drop_cnt_q <= drop_cnt_d;
`endif
      end
   end

   // When both swap indices coincide the two writes carry the same value.
   always_ff @(posedge clk) begin
      if (s_init) begin
         for (int n = 0; n < 256; n++) sbox_q[n] <= 8'(n);
      end else if (s_swap) begin
         sbox_q[swap_a] <= sbox_q[j_new];
         sbox_q[j_new]  <= sbox_q[swap_a];
      end
   end

   assign key_ready = (state_q == ST_READY) || (state_q == ST_SWAP) ||
                      (state_q == ST_KEYX)  || (state_q == ST_OUT);
   assign in_ready  = (state_q == ST_READY) && !key_load;
   assign out_valid = (state_q == ST_OUT);
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_rc4_stream_cipher.sv
// tb/tb_rc4_stream_cipher.sv - self-checking bench for rc4_stream_cipher
module tb_rc4_stream_cipher;

`ifdef RC4_DROP_EN
   localparam int DROP  = 4;
   localparam bit KNOWN = 1'b0;
`else
   localparam int DROP  = 0;
   localparam bit KNOWN = 1'b1;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       in_valid, out_ready, sel;
   logic [7:0] in_data;

   logic [23:0] key3;  logic kl3;  logic kr3, ir3, ov3;  logic [7:0] od3;
   logic [31:0] key4;  logic kl4;  logic kr4, ir4, ov4;  logic [7:0] od4;
   logic [79:0] keyab; logic klab; logic iva; logic [7:0] ida;
   logic kra, ira, ova, krb, irb, ovb; logic [7:0] oda, odb;

   rc4_stream_cipher #(.KEY_BYTES(3), .DROP_N(4)) u3 (
      .clk(clk), .rst_n(rst_n), .key_in(key3), .key_load(kl3), .key_ready(kr3),
      .in_valid(in_valid), .in_data(in_data), .in_ready(ir3),
      .out_valid(ov3), .out_data(od3), .out_ready(out_ready));

   rc4_stream_cipher #(.KEY_BYTES(4), .DROP_N(4)) u4 (
      .clk(clk), .rst_n(rst_n), .key_in(key4), .key_load(kl4), .key_ready(kr4),
      .in_valid(in_valid), .in_data(in_data), .in_ready(ir4),
      .out_valid(ov4), .out_data(od4), .out_ready(out_ready));

   rc4_stream_cipher #(.KEY_BYTES(10), .DROP_N(4)) ua (
      .clk(clk), .rst_n(rst_n), .key_in(keyab), .key_load(klab), .key_ready(kra),
      .in_valid(iva), .in_data(ida), .in_ready(ira),
      .out_valid(ova), .out_data(oda), .out_ready(irb));

   rc4_stream_cipher #(.KEY_BYTES(10), .DROP_N(4)) ub (
      .clk(clk), .rst_n(rst_n), .key_in(keyab), .key_load(klab), .key_ready(krb),
      .in_valid(ova), .in_data(oda), .in_ready(irb),
      .out_valid(ovb), .out_data(odb), .out_ready(1'b1));

   wire       sel_ir = sel ? ir4 : ir3;
   wire       sel_ov = sel ? ov4 : ov3;
   wire [7:0] sel_od = sel ? od4 : od3;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference RC4 from the algorithm definition, with optional drop prefix.
   logic [7:0] ks_out[$];
   task automatic rc4_model(input logic [7:0] key[$], input int n);
      int s[256];
      int a, b, tmp;
      for (int k = 0; k < 256; k++) s[k] = k;
      b = 0;
      for (int k = 0; k < 256; k++) begin
         b = (b + s[k] + int'(key[k % key.size()])) % 256;
         tmp = s[k]; s[k] = s[b]; s[b] = tmp;
      end
      a = 0; b = 0;
      ks_out.delete();
      for (int k = 0; k < n + DROP; k++) begin
         a = (a + 1) % 256;
         b = (b + s[a]) % 256;
         tmp = s[a]; s[a] = s[b]; s[b] = tmp;
         if (k >= DROP) ks_out.push_back(8'(s[(s[a] + s[b]) % 256]));
      end
   endtask

   function automatic logic rdy(input int w);
      return (w == 3) ? kr3 : (w == 4) ? kr4 : krb;
   endfunction

   task automatic pulse_load(input int w);
      if (w == 3) kl3 = 1'b1; else if (w == 4) kl4 = 1'b1; else klab = 1'b1;
      @(negedge clk);
      kl3 = 1'b0; kl4 = 1'b0; klab = 1'b0;
   endtask

   // lat = number of rising edges after the key_load sampling edge.
   task automatic wait_ready(input int w, output int lat);
      lat = 0;
      while (!rdy(w) && lat < 2000) begin @(negedge clk); lat++; end
   endtask

   task automatic xfer(input logic [7:0] d, output logic [7:0] q);
      int n = 0;
      while (!sel_ir && n < 1000) begin @(negedge clk); n++; end
      in_data = d; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!sel_ov && n < 1000) begin @(negedge clk); n++; end
      chk("xfer_out_valid", int'(sel_ov), 1);
      q = sel_od;
      @(negedge clk);
   endtask

   logic [7:0] mid_q[$], fin_q[$];
   always @(negedge clk) begin
      if (ova && irb) mid_q.push_back(oda);
      if (ovb) fin_q.push_back(odb);
   end

   logic [7:0] pt1[9]   = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
   logic [7:0] known1[9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
   logic [7:0] pedia[5] = '{8'h70, 8'h65, 8'h64, 8'h69, 8'h61};
   logic [7:0] known2[5] = '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
   logic [7:0] ks3[$], ks4[$], ksab[$], kq[$];

   function automatic logic [7:0] exp2(input int k);
      return KNOWN ? known2[k] : (pedia[k] ^ ks4[k]);
   endfunction

   initial begin
      logic [7:0] q, d, held_d;
      logic [7:0] ptab[16];
      int lat, n;
      bit ok, saw;

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; sel = 1'b0;
      kl3 = 1'b0; kl4 = 1'b0; klab = 1'b0; iva = 1'b0; ida = '0;
      key3 = 24'h79654B; key4 = 32'h696B6957;
      keyab = {16'($urandom), $urandom, $urandom};
      repeat (3) @(negedge clk);
      chk("rst_key_ready", int'(kr4), 0);
      chk("rst_in_ready", int'(ir4), 0);
      chk("rst_out_valid", int'(ov4), 0);
      chk("rst_out_data", int'(od4), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Test 1: key "Key", "Plaintext"; u4 is still idle and must ignore traffic.
      kq.delete(); for (int k = 0; k < 3; k++) kq.push_back(key3[8*k +: 8]);
      rc4_model(kq, 9); ks3 = ks_out;
      kq.delete(); for (int k = 0; k < 4; k++) kq.push_back(key4[8*k +: 8]);
      rc4_model(kq, 16); ks4 = ks_out;
      pulse_load(3);
      wait_ready(3, lat);
      chk("t1_key_ready_lat", lat, 257 + 2*DROP);
      for (int k = 0; k < 9; k++) begin
         xfer(pt1[k], q);
         chk("t1_byte", int'(q), int'(KNOWN ? known1[k] : (pt1[k] ^ ks3[k])));
      end
      chk("t1_idle_in_ready", int'(ir4), 0);
      chk("t1_idle_key_ready", int'(kr4), 0);

      // Test 2: key "Wiki", "pedia", key_ready timing.
      sel = 1'b1;
      pulse_load(4);
      wait_ready(4, lat);
      chk("t2_key_ready_lat", lat, 257 + 2*DROP);
      for (int k = 0; k < 5; k++) begin
         xfer(pedia[k], q);
         chk("t2_byte", int'(q), int'(exp2(k)));
      end

      // Test 4: latency, then 50 cycles of backpressure on stream byte 5.
      d = 8'($urandom);
      chk("t4_in_ready", int'(ir4), 1);
      out_ready = 1'b0; in_data = d; in_valid = 1'b1;
      @(negedge clk); in_valid = 1'b0;
      chk("t4_lat_edge1", int'(ov4), 0);
      @(negedge clk);
      chk("t4_lat_edge2", int'(ov4), 0);
      @(negedge clk);
      chk("t4_lat_edge3", int'(ov4), 1);
      held_d = od4;
      chk("t4_byte5", int'(held_d), int'(d ^ ks4[5]));
      ok = 1'b1;
      for (int c = 0; c < 50; c++) begin
         in_valid = 1'b1; in_data = 8'($urandom);
         @(negedge clk);
         if (!ov4 || od4 !== held_d || ir4) ok = 1'b0;
      end
      in_valid = 1'b0;
      chk("t4_hold", int'(ok), 1);
      out_ready = 1'b1;
      @(negedge clk);
      for (int k = 6; k < 10; k++) begin
         d = 8'($urandom);
         xfer(d, q);
         chk("t4_stream", int'(q), int'(d ^ ks4[k]));
      end

      // Test 3: random 80-bit key, two instances in series recover plaintext.
      kq.delete(); for (int k = 0; k < 10; k++) kq.push_back(keyab[8*k +: 8]);
      rc4_model(kq, 16); ksab = ks_out;
      mid_q.delete(); fin_q.delete();
      pulse_load(10);
      wait_ready(10, lat);
      chk("t3_key_ready_lat", lat, 257 + 2*DROP);
      for (int k = 0; k < 16; k++) begin
         ptab[k] = 8'($urandom);
         n = 0;
         while (!ira && n < 1000) begin @(negedge clk); n++; end
         ida = ptab[k]; iva = 1'b1;
         @(negedge clk); iva = 1'b0;
      end
      n = 0;
      while (fin_q.size() < 16 && n < 2000) begin @(negedge clk); n++; end
      chk("t3_count", fin_q.size(), 16);
      for (int k = 0; k < 16; k++) begin
         if (k < fin_q.size()) begin
            chk("t3_cipher", int'(mid_q[k]), int'(ptab[k] ^ ksab[k]));
            chk("t3_plain", int'(fin_q[k]), int'(ptab[k]));
         end
      end

      // Test 5: key_load during KEYX aborts the byte; rekey reproduces test 2.
      n = 0;
      while (!ir4 && n < 1000) begin @(negedge clk); n++; end
      in_data = 8'h5A; in_valid = 1'b1;
      @(negedge clk); in_valid = 1'b0;
      @(negedge clk);
      kl4 = 1'b1;
      @(negedge clk); kl4 = 1'b0;
      chk("t5_abort_valid", int'(ov4), 0);
      saw = 1'b0; lat = 0;
      while (!kr4 && lat < 2000) begin
         @(negedge clk); lat++;
         if (ov4) saw = 1'b1;
      end
      chk("t5_no_out_valid", int'(saw), 0);
      chk("t5_key_ready_lat", lat, 257 + 2*DROP);
      for (int k = 0; k < 5; k++) begin
         xfer(pedia[k], q);
         chk("t5_byte", int'(q), int'(exp2(k)));
      end

      // Reset mid-KSA: stays unkeyed until a fresh key_load.
      pulse_load(4);
      repeat (100) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      ok = 1'b1;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (kr4 || ir4) ok = 1'b0;
      end
      chk("t5_reset_idle", int'(ok), 1);
      pulse_load(4);
      wait_ready(4, lat);
      chk("t5_rekey_lat", lat, 257 + 2*DROP);
      xfer(pedia[0], q);
      chk("t5_rekey_byte", int'(q), int'(exp2(0)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
